// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
// Adds two WIDTH-bit operands by stepping one 4-bit carry-lookahead slice
// across the operands, least-significant nibble first, one nibble per clock.
// Operands arrive and results leave over valid/ready handshakes.
// Optional feature macro: CLA_SUB_EN adds a 'sub' port that turns the
// operation into a-b (b inverted at capture, carry-in forced to 1).
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operands held as nibble arrays so the active nibble is a plain index.
    logic [N-1:0][3:0] op_a;
    logic [N-1:0][3:0] op_b;
    logic [N-1:0][3:0] sum_r;
    logic [IW-1:0]     idx;
    logic              carry;
    logic              cout_r;

    logic              accept;
    logic              last_step;
    logic [4:0]        slice_res;

    // 4-bit generate/propagate lookahead; returns {c4, s[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g = x & y;
        p = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (idx == LAST_IDX);
    assign slice_res = cla4(op_a[idx], op_b[idx], carry);

    assign sum  = sum_r;
    assign cout = cout_r;

    // State register; reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode, purely from the state register and inputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture at the input handshake; held untouched until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= a;
`ifdef CLA_SUB_EN
            op_b <= sub ? ~b : b;
`else
            op_b <= b;
`endif
        end
    end

    // Nibble stepping: carry chain, result nibbles, index and final carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
        end else if (accept) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            idx    <= '0;
`ifdef CLA_SUB_EN
            carry  <= sub ? 1'b1 : cin;
`else
            carry  <= cin;
`endif
        end else if (state == RUN) begin
            sum_r[idx] <= slice_res[3:0];
            carry      <= slice_res[4];
            if (last_step) begin
                cout_r <= slice_res[4];
                idx    <= '0;
            end else begin
                idx    <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer (WIDTH=16): directed and random additions
// compared against a plain-arithmetic reference, plus handshake, stall,
// reset and back-to-back timing checks. Build with CLA_SUB_EN to add
// the subtract cases.
module tb_cla_nibble_sequencer;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    cla_nibble_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, carry-out is bit W of the wide sum.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
        if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; stall_cycles holds out_ready low while checking stability.
    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic xs, input int stall_cycles);
        logic [W:0] exp;
        int cycles;
        exp = model(xa, xb, xc, xs);
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b0;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, ".latency"}, 32'(cycles), 32'(N));
        check({tag, ".sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < stall_cycles; i++) begin
            tick();
            check({tag, ".stall_ov"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_ir"}, 32'(in_ready), 32'd0);
            check({tag, ".stall_sum"}, 32'(sum), 32'(exp[W-1:0]));
            check({tag, ".stall_cout"}, 32'(cout), 32'(exp[W]));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".post_ov"}, 32'(out_valid), 32'd0);
        check({tag, ".post_ir"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".sum"}, 32'(sum), 32'd0);
        check({tag, ".cout"}, 32'(cout), 32'd0);
    endtask

    initial begin
        logic [W:0] e1, e2;
        int rise_cnt, rise0, rise1;
        logic prev_ov;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("t9999", 16'h9999, 16'h9999, 1'b1, 1'b0, 0);
        do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
        do_op("stall", 16'h1234, 16'hF00D, 1'b0, 1'b0, 5);

        // Reset in RUN after two nibble steps.
        @(negedge clk);
        a = 16'hABCD; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0);

`ifdef CLA_SUB_EN
        do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 0);
`endif

        for (int k = 0; k < 8; k++) begin
            do_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0, k % 2);
        end

        // Back-to-back with in_valid and out_ready held high.
        e1 = model(16'h8001, 16'h7FFF, 1'b0, 1'b0);
        e2 = model(16'h0F0F, 16'h00F1, 1'b1, 1'b0);
        @(negedge clk);
        a = 16'h8001; b = 16'h7FFF; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
        rise_cnt = 0; rise0 = 0; rise1 = 0; prev_ov = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (out_valid && !prev_ov) begin
                if (rise_cnt == 0) begin
                    rise0 = c;
                    check("b2b.sum0", 32'(sum), 32'(e1[W-1:0]));
                    check("b2b.cout0", 32'(cout), 32'(e1[W]));
                end else begin
                    rise1 = c;
                    check("b2b.sum1", 32'(sum), 32'(e2[W-1:0]));
                    check("b2b.cout1", 32'(cout), 32'(e2[W]));
                end
                rise_cnt++;
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b.rises", 32'(rise_cnt), 32'd2);
        check("b2b.first", 32'(rise0), 32'(N));
        check("b2b.spacing", 32'(rise1 - rise0), 32'(N + 2));
        tick();
        check("b2b.idle", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
